// File: rtl/coinc_trigger_ctrl_pkg.sv
// Shared types and helpers for the coincidence trigger controller.
package mucosmic_trig_pkg;
   typedef enum logic [2:0] {IDLE, WINDOW, EVAL, FIRE, DEAD} state_t;

   localparam int TS_W_DEF  = 32;
   localparam int CNT_W_DEF = 16;
   localparam int MAX_CH    = 16;
   localparam int POP_W     = 5;

   // Callers zero-extend their N_CH-wide map to MAX_CH bits.
   function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < MAX_CH; i++) n = n + POP_W'(v[i]);
      return n;
   endfunction
endpackage

// File: rtl/coinc_trigger_ctrl_if.sv
// Event record handshake between the trigger controller and readout.
interface coinc_trigger_ctrl_if import mucosmic_trig_pkg::*; #(
   parameter int N_CH = 4,
   parameter int TS_W = TS_W_DEF
);
   localparam int FOLD_W = $clog2(N_CH + 1);

   logic              evt_valid;
   logic              evt_ready;
   logic [N_CH-1:0]   evt_hitmap;
   logic [FOLD_W-1:0] evt_fold;
   logic [TS_W-1:0]   evt_timestamp;

   modport master (output evt_valid, evt_hitmap, evt_fold, evt_timestamp, input evt_ready);
   modport slave  (input evt_valid, evt_hitmap, evt_fold, evt_timestamp, output evt_ready);
endinterface

// File: rtl/coinc_trigger_ctrl_edge_detect.sv
// Per-channel rising-edge detector; prev resets high so a level held at reset release is not an edge.
module trig_edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic trig,
   input  logic mask,
   output logic rise
);
   logic prev;

   always_ff @(posedge clk) begin
      if (rst) prev <= 1'b1;
      else     prev <= trig;
   end

   assign rise = trig & ~prev & mask;
endmodule

// File: rtl/coinc_trigger_ctrl.sv
// Coincidence window / fold trigger: collects channel edges, issues event records, enforces dead time.
module coinc_trigger_ctrl import mucosmic_trig_pkg::*; #(
   parameter  int N_CH   = 4,
   parameter  int WIN_W  = 8,
   parameter  int DEAD_W = 16,
   parameter  int TS_W   = TS_W_DEF,
   parameter  int CNT_W  = CNT_W_DEF,
   localparam int FOLD_W = $clog2(N_CH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [N_CH-1:0]       trig_in,
   input  logic [N_CH-1:0]       ch_mask,
   input  logic [WIN_W-1:0]      coinc_window,
   input  logic [FOLD_W-1:0]     min_fold,
   input  logic [DEAD_W-1:0]     dead_time,
   coinc_trigger_ctrl_if.master  evt,
   output logic                  busy,
   output logic [CNT_W-1:0]      acc_count,
   output logic [CNT_W-1:0]      rej_count
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t            state;
   logic [N_CH-1:0]   rise, hit_q, evt_hit_q;
   logic [WIN_W-1:0]  win_cnt;
   logic [DEAD_W-1:0] dead_cnt;
   logic [TS_W-1:0]   ts, ts_lat, evt_ts_q;
   logic [FOLD_W-1:0] fold, fold_min, evt_fold_q;
   logic              valid_q;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      trig_edge_detect u_edge (
         .clk  (clk),
         .rst  (rst),
         .trig (trig_in[i]),
         .mask (ch_mask[i]),
         .rise (rise[i])
      );
   end

   assign fold     = FOLD_W'(popcount(MAX_CH'(hit_q)));
   assign fold_min = (min_fold == '0) ? FOLD_W'(1) : min_fold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         ts         <= '0;
         ts_lat     <= '0;
         hit_q      <= '0;
         win_cnt    <= '0;
         dead_cnt   <= '0;
         valid_q    <= 1'b0;
         evt_hit_q  <= '0;
         evt_fold_q <= '0;
         evt_ts_q   <= '0;
         acc_count  <= '0;
         rej_count  <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         case (state)
            IDLE: if (enable && |rise) begin
               hit_q   <= rise;
               ts_lat  <= ts;
               win_cnt <= coinc_window;
               state   <= (coinc_window != '0) ? WINDOW : EVAL;
            end
            WINDOW: begin
               hit_q   <= hit_q | rise;
               win_cnt <= win_cnt - WIN_W'(1);
               if (win_cnt == WIN_W'(1)) state <= EVAL;
            end
            EVAL: if (fold >= fold_min) begin
               evt_hit_q  <= hit_q;
               evt_fold_q <= fold;
               evt_ts_q   <= ts_lat;
               valid_q    <= 1'b1;
               state      <= FIRE;
            end else begin
               if (rej_count != CNT_MAX) rej_count <= rej_count + CNT_W'(1);
               state <= IDLE;
            end
            // Record is frozen here; edges arriving meanwhile are dropped.
            FIRE: if (evt.evt_ready) begin
               valid_q  <= 1'b0;
               if (acc_count != CNT_MAX) acc_count <= acc_count + CNT_W'(1);
               dead_cnt <= dead_time;
               state    <= (dead_time != '0) ? DEAD : IDLE;
            end
            DEAD: begin
               dead_cnt <= dead_cnt - DEAD_W'(1);
               if (dead_cnt == DEAD_W'(1)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy              = (state != IDLE);
   assign evt.evt_valid     = valid_q;
   assign evt.evt_hitmap    = evt_hit_q;
   assign evt.evt_fold      = evt_fold_q;
   assign evt.evt_timestamp = evt_ts_q;
endmodule

// File: tb/tb_coinc_trigger_ctrl.sv
// Randomized bench for coinc_trigger_ctrl against a cycle-numbered event model.
module tb_coinc_trigger_ctrl;
   localparam int N_CH   = 4;
   localparam int WIN_W  = 4;
   localparam int DEAD_W = 6;
   localparam int TS_W   = 8;
   localparam int CNT_W  = 3;
   localparam int FOLD_W = 3;
   localparam int CMAX   = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst, enable;
   logic [N_CH-1:0]   trig_in, ch_mask;
   logic [WIN_W-1:0]  coinc_window;
   logic [FOLD_W-1:0] min_fold;
   logic [DEAD_W-1:0] dead_time;
   logic              busy;
   logic [CNT_W-1:0]  acc_count, rej_count;

   coinc_trigger_ctrl_if #(.N_CH(N_CH), .TS_W(TS_W)) evt_if ();

   coinc_trigger_ctrl #(
      .N_CH(N_CH), .WIN_W(WIN_W), .DEAD_W(DEAD_W), .TS_W(TS_W), .CNT_W(CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .trig_in      (trig_in),
      .ch_mask      (ch_mask),
      .coinc_window (coinc_window),
      .min_fold     (min_fold),
      .dead_time    (dead_time),
      .evt          (evt_if),
      .busy         (busy),
      .acc_count    (acc_count),
      .rej_count    (rej_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: c is the timestamp value seen at the current posedge.
   int              c, elig, open_c, m_acc, m_rej;
   bit              win, pend;
   logic [N_CH-1:0] prev, hits, m_hit;
   int              m_fold;
   logic [TS_W-1:0] m_ts, open_ts;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      c = 0; elig = 0; win = 0; pend = 0; prev = '1; hits = '0;
      m_acc = 0; m_rej = 0;
   endtask

   task automatic model_step();
      logic [N_CH-1:0] e;
      int minf;
      if (rst) model_reset();
      else begin
         e    = trig_in & ~prev & ch_mask;
         prev = trig_in;
         minf = (min_fold == 0) ? 1 : int'(min_fold);
         if (pend) begin
            if (evt_if.evt_ready) begin
               pend  = 0;
               m_acc = (m_acc == CMAX) ? CMAX : m_acc + 1;
               elig  = c + int'(dead_time) + 1;
            end
         end else if (win) begin
            if (c <= open_c + int'(coinc_window)) hits |= e;
            else begin
               win = 0;
               if ($countones(hits) >= minf) begin
                  pend = 1; m_hit = hits; m_fold = $countones(hits); m_ts = open_ts;
               end else begin
                  m_rej = (m_rej == CMAX) ? CMAX : m_rej + 1;
                  elig  = c + 1;
               end
            end
         end else if (c >= elig && enable && e != '0) begin
            win = 1; open_c = c; hits = e; open_ts = TS_W'(c);
         end
         c++;
      end
   endtask

   task automatic check_outputs();
      logic exp_busy;
      exp_busy = win || pend || (c < elig);
      chk("evt_valid", 32'(evt_if.evt_valid), 32'(pend));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("acc_count", 32'(acc_count), 32'(m_acc));
      chk("rej_count", 32'(rej_count), 32'(m_rej));
      if (pend) begin
         chk("evt_hitmap", 32'(evt_if.evt_hitmap), 32'(m_hit));
         chk("evt_fold", 32'(evt_if.evt_fold), 32'(m_fold));
         chk("evt_timestamp", 32'(evt_if.evt_timestamp), 32'(m_ts));
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic rand_cycle(input int ready_pct);
      for (int i = 0; i < N_CH; i++)
         if ($urandom_range(99) < 12) trig_in[i] = ~trig_in[i];
      evt_if.evt_ready = ($urandom_range(99) < ready_pct);
      enable           = ($urandom_range(15) != 0);
      step();
   endtask

   task automatic run_block(input int w, input int dead, input int minf,
                            input logic [N_CH-1:0] mask, input int ready_pct, input int n);
      coinc_window = WIN_W'(w);
      dead_time    = DEAD_W'(dead);
      min_fold     = FOLD_W'(minf);
      ch_mask      = mask;
      trig_in      = N_CH'($urandom);
      rst          = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      repeat (n) rand_cycle(ready_pct);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; trig_in = '0; ch_mask = '1;
      coinc_window = '0; min_fold = '0; dead_time = '0; evt_if.evt_ready = 1'b0;
      model_reset();
      @(negedge clk);

      run_block(3, 0, 2, 4'hF, 50, 300);
      run_block(2, 3, 3, 4'hF, 30, 300);
      run_block(0, 0, 1, 4'hF, 100, 300);
      run_block(1, 4, 1, 4'b1110, 5, 300);
      run_block(4, 2, 0, 4'hF, 60, 300);
      run_block(5, 6, 4, 4'hF, 50, 300);
      for (int b = 0; b < 4; b++)
         run_block($urandom_range(6), $urandom_range(7), $urandom_range(4),
                   N_CH'($urandom), $urandom_range(10, 90), 250);

      // Reset while an event is held in FIRE, with triggers high through release.
      coinc_window = 1; dead_time = 2; min_fold = 1; ch_mask = '1;
      enable = 1'b1; evt_if.evt_ready = 1'b0; trig_in = '0;
      rst = 1'b1; step();
      rst = 1'b0; step(); step();
      trig_in = '1;
      for (int k = 0; k < 20 && !evt_if.evt_valid; k++) step();
      chk("fire_reached", 32'(evt_if.evt_valid), 32'd1);
      repeat (3) step();
      rst = 1'b1; step();
      chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("rst_acc", 32'(acc_count), 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         evt_if.evt_ready = ($urandom_range(1) == 1);
         step();
      end
      chk("no_evt_after_rst", 32'(evt_if.evt_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
